// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and the 4-bit ALU control encoding for the
// execute-stage ALU. The first five control codes keep the legacy values
// so the decoder remains drop-in compatible with the older 4-bit decoder.
package alu_pkg;

    // aluOp codes driven by the main control unit
    localparam logic [1:0] ALU_OP_LS    = 2'b00;  // load/store address add
    localparam logic [1:0] ALU_OP_BR    = 2'b01;  // branch compare subtract
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;  // R-type, operation from funct
    localparam logic [1:0] ALU_OP_ADDI  = 2'b11;  // add immediate

    // R-type funct field values
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_MUL  = 6'b011000;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;

    typedef enum logic [3:0] {
        CTRL_AND     = 4'b0000,
        CTRL_OR      = 4'b0001,
        CTRL_ADD     = 4'b0010,
        CTRL_XOR     = 4'b0011,
        CTRL_SUB     = 4'b0110,
        CTRL_SLT     = 4'b0111,
        CTRL_SLTU    = 4'b1000,
        CTRL_SLL     = 4'b1001,
        CTRL_SRL     = 4'b1010,
        CTRL_SRA     = 4'b1011,
        CTRL_NOR     = 4'b1100,
        CTRL_MUL     = 4'b1101,
        CTRL_ILLEGAL = 4'b1111
    } alu_ctrl_t;

    // Two's-complement overflow from operand and result sign bits.
    // For subtraction the effective B sign is inverted.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic r_msb, input logic is_sub);
        logic b_eff;
        b_eff = b_msb ^ is_sub;
        return (a_msb == b_eff) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: combinational aluOp/funct decoder producing the 4-bit ALU
// control code and a flag saying whether signed overflow is reported.
// Build macro ALU_MUL_EN makes funct 011000 decode as MUL instead of illegal.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output alu_ctrl_t  ctrl,
    output logic       ovf_chk
);

    // Map the control inputs to an ALU operation; unknown funct is illegal.
    always_comb begin
        ctrl    = CTRL_ILLEGAL;
        ovf_chk = 1'b0;
        case (alu_op)
            ALU_OP_LS, ALU_OP_ADDI: begin
                ctrl    = CTRL_ADD;
                ovf_chk = 1'b1;
            end
            ALU_OP_BR: begin
                ctrl    = CTRL_SUB;
                ovf_chk = 1'b1;
            end
            ALU_OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: begin
                        ctrl    = CTRL_ADD;
                        ovf_chk = 1'b1;
                    end
                    FUNCT_ADDU: ctrl = CTRL_ADD;
                    FUNCT_SUB: begin
                        ctrl    = CTRL_SUB;
                        ovf_chk = 1'b1;
                    end
                    FUNCT_SUBU: ctrl = CTRL_SUB;
                    FUNCT_AND:  ctrl = CTRL_AND;
                    FUNCT_OR:   ctrl = CTRL_OR;
                    FUNCT_XOR:  ctrl = CTRL_XOR;
                    FUNCT_NOR:  ctrl = CTRL_NOR;
                    FUNCT_SLT:  ctrl = CTRL_SLT;
                    FUNCT_SLTU: ctrl = CTRL_SLTU;
                    FUNCT_SLL:  ctrl = CTRL_SLL;
                    FUNCT_SRL:  ctrl = CTRL_SRL;
                    FUNCT_SRA:  ctrl = CTRL_SRA;
`ifdef ALU_MUL_EN
                    FUNCT_MUL:  ctrl = CTRL_MUL;
`endif
                    default:    ctrl = CTRL_ILLEGAL;
                endcase
            end
            default: ctrl = CTRL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execute-stage ALU. Decodes aluOp/funct, computes
// a WIDTH-bit result and holds it in an output register until consumed.
// Build macro ALU_MUL_EN adds an iterative unsigned shift-add multiplier
// (one partial product per cycle, WIDTH iterations).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [5:0]         funct,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow,
    output logic               illegal
);

    alu_ctrl_t        ctrl;
    logic             ovf_chk;
    logic             accept;
    logic             pop;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH-1:0] sra_res;
    logic [WIDTH-1:0] calc_res;
    logic             calc_ovf;
    logic             calc_ill;
    logic             calc_zero;
    logic             slt_bit;
    logic             sltu_bit;

    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             overflow_reg;
    logic             illegal_reg;

    alu_ctrl_dec u_dec (
        .alu_op  (alu_op),
        .funct   (funct),
        .ctrl    (ctrl),
        .ovf_chk (ovf_chk)
    );

    assign sum      = src_a + src_b;
    assign diff     = src_a - src_b;
    assign sltu_bit = (src_a < src_b);
    assign slt_bit  = ($signed(src_a) < $signed(src_b));
    assign sra_res  = $unsigned($signed(src_b) >>> shamt);

    // Bitwise logic unit, one lane per bit; NOR is the fall-through case.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign logic_res[gi] = (ctrl == CTRL_AND) ? (src_a[gi] & src_b[gi]) :
                                   (ctrl == CTRL_OR)  ? (src_a[gi] | src_b[gi]) :
                                   (ctrl == CTRL_XOR) ? (src_a[gi] ^ src_b[gi]) :
                                                        ~(src_a[gi] | src_b[gi]);
        end
    endgenerate

    // Select the single-cycle result and flags for the decoded operation.
    always_comb begin
        calc_res = '0;
        calc_ovf = 1'b0;
        calc_ill = 1'b0;
        case (ctrl)
            CTRL_ADD: begin
                calc_res = sum;
                calc_ovf = ovf_chk &&
                           signed_ovf(src_a[WIDTH-1], src_b[WIDTH-1], sum[WIDTH-1], 1'b0);
            end
            CTRL_SUB: begin
                calc_res = diff;
                calc_ovf = ovf_chk &&
                           signed_ovf(src_a[WIDTH-1], src_b[WIDTH-1], diff[WIDTH-1], 1'b1);
            end
            CTRL_AND, CTRL_OR, CTRL_XOR, CTRL_NOR: calc_res = logic_res;
            CTRL_SLT:  calc_res = {{(WIDTH-1){1'b0}}, slt_bit};
            CTRL_SLTU: calc_res = {{(WIDTH-1){1'b0}}, sltu_bit};
            CTRL_SLL:  calc_res = src_b << shamt;
            CTRL_SRL:  calc_res = src_b >> shamt;
            CTRL_SRA:  calc_res = sra_res;
            CTRL_MUL:  calc_res = '0;  // produced by the iterative path
            default:   calc_ill = 1'b1;
        endcase
    end

    assign calc_zero = (calc_res == '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid_reg && out_ready;

`ifdef ALU_MUL_EN
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t             state_reg;
    logic [SHAMT_W-1:0] cnt_reg;
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]   acc_next;

    // Add the current partial product when the multiplier LSB is set.
    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign in_ready = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);

    // Control FSM: single-cycle capture in IDLE, shift-add iterations in MUL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            acc_reg       <= '0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (ctrl == CTRL_MUL) begin
                            // Previous result was consumed (accept implies it);
                            // nothing is valid until the product is done.
                            state_reg     <= ST_MUL;
                            cnt_reg       <= '0;
                            mcand_reg     <= src_a;
                            mplier_reg    <= src_b;
                            acc_reg       <= '0;
                            out_valid_reg <= 1'b0;
                        end else begin
                            out_valid_reg <= 1'b1;
                            result_reg    <= calc_res;
                            zero_reg      <= calc_zero;
                            overflow_reg  <= calc_ovf;
                            illegal_reg   <= calc_ill;
                        end
                    end else if (pop) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                ST_MUL: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    // Last of WIDTH iterations: publish the low product bits.
                    if (cnt_reg == '1) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b1;
                        result_reg    <= acc_next;
                        zero_reg      <= (acc_next == '0);
                        overflow_reg  <= 1'b0;
                        illegal_reg   <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
`else
    assign in_ready = !out_valid_reg || out_ready;

    // Output register: capture on accept, drop valid once consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            result_reg    <= calc_res;
            zero_reg      <= calc_zero;
            overflow_reg  <= calc_ovf;
            illegal_reg   <= calc_ill;
        end else if (pop) begin
            out_valid_reg <= 1'b0;
        end
    end
`endif

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign overflow  = overflow_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: self-checking bench for alu_exec_unit. Directed vectors,
// backpressure, illegal ops, randomized scoreboard against a behavioural
// model, and (when ALU_MUL_EN is defined) the iterative multiplier.
module tb_alu_exec_unit;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    alu_op;
    logic [5:0]    funct;
    logic [SW-1:0] shamt;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          zero;
    logic          overflow;
    logic          illegal;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
        logic         ill;
    } exp_t;

    typedef struct packed {
        logic [1:0]    op;
        logic [5:0]    f;
        logic [SW-1:0] sh;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        exp_t          e;
    } vec_t;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .shamt     (shamt),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    // Behavioural reference: wide signed/unsigned integer arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                   input logic [SW-1:0] sh, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb, r, smax, smin;
        logic [2*W-1:0] p;
        int     kind;  // 0 add checked, 1 add plain, 2 sub checked, 3 sub plain, 4 other
        e    = '0;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        smax = (longint'(1) <<< (W-1)) - 1;
        smin = -(longint'(1) <<< (W-1));
        kind = 4;
        if (op == 2'b00 || op == 2'b11) kind = 0;
        else if (op == 2'b01) kind = 2;
        else begin
            case (f)
                6'h20: kind = 0;
                6'h21: kind = 1;
                6'h22: kind = 2;
                6'h23: kind = 3;
                6'h24: e.res = a & b;
                6'h25: e.res = a | b;
                6'h26: e.res = a ^ b;
                6'h27: e.res = ~(a | b);
                6'h2a: e.res = (sa < sb) ? 1 : 0;
                6'h2b: e.res = (a < b) ? 1 : 0;
                6'h00: e.res = b << sh;
                6'h02: e.res = b >> sh;
                6'h03: begin
                    r     = sb >>> sh;
                    e.res = r[W-1:0];
                end
`ifdef ALU_MUL_EN
                6'h18: begin
                    p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                    e.res = p[W-1:0];
                end
`endif
                default: e.ill = 1'b1;
            endcase
        end
        if (kind == 0 || kind == 1) begin
            r     = sa + sb;
            e.res = r[W-1:0];
            e.ovf = (kind == 0) && (r > smax || r < smin);
        end else if (kind == 2 || kind == 3) begin
            r     = sa - sb;
            e.res = r[W-1:0];
            e.ovf = (kind == 2) && (r > smax || r < smin);
        end
        if (e.ill) e.res = '0;
        e.zero = (e.res == '0);
        return e;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [5:0] rand_funct();
        logic [5:0] f;
        case ($urandom_range(0, 14))
            0:       f = 6'h20;
            1:       f = 6'h21;
            2:       f = 6'h22;
            3:       f = 6'h23;
            4:       f = 6'h24;
            5:       f = 6'h25;
            6:       f = 6'h26;
            7:       f = 6'h27;
            8:       f = 6'h2a;
            9:       f = 6'h2b;
            10:      f = 6'h00;
            11:      f = 6'h02;
            12:      f = 6'h03;
            default: f = 6'($urandom_range(0, 63));
        endcase
`ifdef ALU_MUL_EN
        if (f == 6'h18) f = 6'h3f;
`endif
        return f;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [SW-1:0] sh,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        alu_op   = op;
        funct    = f;
        shamt    = sh;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
    endtask

    // Issue one op, wait for accept, then for out_valid; lat counts cycles
    // from the accept edge to the first sample showing out_valid.
    task automatic send(input logic [1:0] op, input logic [5:0] f, input logic [SW-1:0] sh,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output bit ok);
        int n;
        ok  = 1'b0;
        lat = 0;
        @(posedge clk);
        #1;
        drive(op, f, sh, a, b);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = '0;
        funct     = '0;
        shamt     = '0;
        src_a     = '0;
        src_b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, result, zero, overflow, illegal} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b r=%h z=%b o=%b i=%b want all 0",
                     out_valid, result, zero, overflow, illegal);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        $display("txn reset: in_ready=%b out_valid=%b", in_ready, out_valid);
    endtask

    task automatic test_directed();
        vec_t vecs[$];
        exp_t obs;
        int   lat;
        bit   ok;
        out_ready = 1'b1;
        vecs.push_back('{2'b10, 6'h20, 5'd0,  32'h7FFFFFFF, 32'h00000001, '{32'h80000000, 1'b0, 1'b1, 1'b0}});
        vecs.push_back('{2'b01, 6'h00, 5'd0,  32'h00001234, 32'h00001234, '{32'h00000000, 1'b1, 1'b0, 1'b0}});
        vecs.push_back('{2'b10, 6'h2b, 5'd0,  32'h00000001, 32'hFFFFFFFF, '{32'h00000001, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{2'b10, 6'h2a, 5'd0,  32'h00000001, 32'hFFFFFFFF, '{32'h00000000, 1'b1, 1'b0, 1'b0}});
        vecs.push_back('{2'b10, 6'h03, 5'd4,  32'h00000000, 32'hF0000000, '{32'hFF000000, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{2'b10, 6'h02, 5'd4,  32'h00000000, 32'hF0000000, '{32'h0F000000, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{2'b10, 6'h21, 5'd0,  32'h7FFFFFFF, 32'h00000001, '{32'h80000000, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{2'b10, 6'h22, 5'd0,  32'h80000000, 32'h00000001, '{32'h7FFFFFFF, 1'b0, 1'b1, 1'b0}});
        vecs.push_back('{2'b10, 6'h23, 5'd0,  32'h80000000, 32'h00000001, '{32'h7FFFFFFF, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{2'b11, 6'h00, 5'd0,  32'hFFFFFFFF, 32'h00000001, '{32'h00000000, 1'b1, 1'b0, 1'b0}});
        vecs.push_back('{2'b00, 6'h00, 5'd0,  32'h80000000, 32'h80000000, '{32'h00000000, 1'b1, 1'b1, 1'b0}});
        vecs.push_back('{2'b10, 6'h27, 5'd0,  32'h00000000, 32'h00000000, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{2'b10, 6'h00, 5'd31, 32'h00000000, 32'h00000001, '{32'h80000000, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{2'b10, 6'h26, 5'd0,  32'hA5A5A5A5, 32'hFFFF0000, '{32'h5A5AA5A5, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{2'b10, 6'h24, 5'd0,  32'hF0F0F0F0, 32'hFF00FF00, '{32'hF000F000, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{2'b10, 6'h25, 5'd0,  32'hF0F0F0F0, 32'h0F0F0000, '{32'hFFFFF0F0, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{2'b10, 6'h2a, 5'd0,  32'hFFFFFFFE, 32'h00000001, '{32'h00000001, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{2'b10, 6'h2b, 5'd0,  32'hFFFFFFFE, 32'h00000001, '{32'h00000000, 1'b1, 1'b0, 1'b0}});
        vecs.push_back('{2'b00, 6'h3f, 5'd0,  32'h00000005, 32'h00000005, '{32'h0000000A, 1'b0, 1'b0, 1'b0}});
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].f, vecs[i].sh, vecs[i].a, vecs[i].b, lat, ok);
            obs = {result, zero, overflow, illegal};
            checks++;
            if (!ok || lat != 1) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got ok=%b lat=%0d want ok=1 lat=1", i, ok, lat);
            end
            checks++;
            if (obs !== vecs[i].e) begin
                failures++;
                $display("FAIL directed_result[%0d]: got r=%h z=%b o=%b i=%b want r=%h z=%b o=%b i=%b",
                         i, obs.res, obs.zero, obs.ovf, obs.ill,
                         vecs[i].e.res, vecs[i].e.zero, vecs[i].e.ovf, vecs[i].e.ill);
            end
            $display("txn directed[%0d]: op=%b f=%h a=%h b=%h -> r=%h z=%b o=%b i=%b",
                     i, vecs[i].op, vecs[i].f, vecs[i].a, vecs[i].b,
                     obs.res, obs.zero, obs.ovf, obs.ill);
        end
    endtask

    task automatic test_illegal();
        int lat;
        bit ok;
        out_ready = 1'b1;
        send(2'b10, 6'h3f, 5'd0, 32'h12345678, 32'h9ABCDEF0, lat, ok);
        checks++;
        if (!ok || lat != 1 || {result, zero, overflow, illegal} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL illegal_3f: got ok=%b lat=%0d r=%h z=%b o=%b i=%b want lat=1 r=0 z=1 o=0 i=1",
                     ok, lat, result, zero, overflow, illegal);
        end
        $display("txn illegal funct=3f: r=%h z=%b i=%b", result, zero, illegal);
`ifndef ALU_MUL_EN
        send(2'b10, 6'h18, 5'd0, 32'h00000003, 32'hFFFFFFFF, lat, ok);
        checks++;
        if (!ok || lat != 1 || {result, zero, overflow, illegal} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL illegal_mul_disabled: got ok=%b lat=%0d r=%h z=%b o=%b i=%b want lat=1 r=0 z=1 o=0 i=1",
                     ok, lat, result, zero, overflow, illegal);
        end
        $display("txn illegal funct=18: r=%h z=%b i=%b lat=%0d", result, zero, illegal, lat);
`endif
    endtask

    task automatic test_backpressure();
        exp_t obs;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive(2'b10, 6'h20, 5'd0, 32'd5, 32'd7);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_first_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        drive(2'b10, 6'h26, 5'd0, 32'h000000FF, 32'h0000000F);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            obs = {result, zero, overflow, illegal};
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== {32'd12, 1'b0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got in_ready=%b v=%b r=%h want in_ready=0 v=1 r=0000000c",
                         c, in_ready, out_valid, result);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        obs = {result, zero, overflow, illegal};
        checks++;
        if (out_valid !== 1'b1 || obs !== {32'h000000F0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL bp_second: got v=%b r=%h want v=1 r=000000f0", out_valid, result);
        end
        $display("txn backpressure: second r=%h", result);
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_dup: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        exp_t obs;
        exp_t hold_obs;
        bit   hold_pending;
        int   accepted;
        int   cyc;
        accepted     = 0;
        cyc          = 0;
        hold_pending = 1'b0;
        hold_obs     = '0;
        while ((accepted < 100 || q.size() != 0) && cyc < 3000) begin
            @(posedge clk);
            #1;
            if (accepted < 100) begin
                drive(2'($urandom_range(0, 3)), rand_funct(), SW'($urandom_range(0, W-1)),
                      rand_operand(), rand_operand());
                in_valid = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            obs = {result, zero, overflow, illegal};
            if (hold_pending) begin
                checks++;
                if (out_valid !== 1'b1 || obs !== hold_obs) begin
                    failures++;
                    $display("FAIL rand_hold: got v=%b r=%h want v=1 r=%h", out_valid, obs.res, hold_obs.res);
                end
            end
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                failures++;
                $display("FAIL rand_in_ready: got %b want %b", in_ready, (!out_valid || out_ready));
            end
            hold_pending = out_valid && !out_ready;
            hold_obs     = obs;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_spurious: got result r=%h want no result pending", obs.res);
                end else begin
                    e = q.pop_front();
                    if (obs !== e) begin
                        failures++;
                        $display("FAIL rand_result: got r=%h z=%b o=%b i=%b want r=%h z=%b o=%b i=%b",
                                 obs.res, obs.zero, obs.ovf, obs.ill, e.res, e.zero, e.ovf, e.ill);
                    end
                    $display("txn random: r=%h z=%b o=%b i=%b", obs.res, obs.zero, obs.ovf, obs.ill);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(alu_op, funct, shamt, src_a, src_b));
                accepted++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (accepted < 100 || q.size() != 0) begin
            failures++;
            $display("FAIL rand_timeout: got accepted=%0d pending=%0d want 100/0", accepted, q.size());
        end
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        int lat;
        bit ready_bad;
        bit valid_bad;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive(2'b10, 6'h18, 5'd0, 32'h00000003, 32'hFFFFFFFF);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mul_accept_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        lat       = 0;
        ready_bad = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
            if (in_ready) ready_bad = 1'b1;
        end
        checks++;
        if (lat != W + 1 || ready_bad) begin
            failures++;
            $display("FAIL mul_latency: got lat=%0d ready_seen=%b want lat=%0d ready_seen=0", lat, ready_bad, W + 1);
        end
        checks++;
        if ({result, zero, overflow, illegal} !== {32'hFFFFFFFD, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mul_result: got r=%h z=%b o=%b i=%b want r=fffffffd z=0 o=0 i=0",
                     result, zero, overflow, illegal);
        end
        $display("txn mul: 3*ffffffff -> r=%h lat=%0d", result, lat);
        // Second run, aborted by reset ten cycles into the multiply.
        @(posedge clk);
        #1;
        drive(2'b10, 6'h18, 5'd0, 32'd5, 32'd7);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mul_reset_async: got out_valid=%b want 0", out_valid);
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        ready_bad = 1'b0;
        valid_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) valid_bad = 1'b1;
            if (!in_ready) ready_bad = 1'b1;
        end
        checks++;
        if (valid_bad || ready_bad) begin
            failures++;
            $display("FAIL mul_reset_abort: got valid_seen=%b not_ready_seen=%b want 0/0", valid_bad, ready_bad);
        end
        $display("txn mul reset abort: out_valid=%b in_ready=%b", out_valid, in_ready);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_backpressure();
        test_random();
`ifdef ALU_MUL_EN
        test_mul();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised execute-stage ALU with integrated control decode. Generalises the fixed 4-bit control decoder into a handshaked unit that decodes aluOp/funct, computes a WIDTH-bit result and registers it.
- Adds shifts, xor/nor/sltu, overflow and illegal-op flags, and an optional iterative multiplier.
- Sits between ID/EX and EX/MEM. Either pipeline side may stall it.

Parameters:
- WIDTH, 32, datapath width in bits (>=8, power of 2).
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  unit accepts operation this cycle
- alu_op  input  2  00 load/store add, 01 branch sub, 10 R-type (use funct), 11 addi add
- funct  input  6  R-type function field
- shamt  input  SHAMT_W  shift amount for sll/srl/sra
- src_a  input  WIDTH  operand A (rs)
- src_b  input  WIDTH  operand B (rt/imm)
- out_valid  output  1  result registered and held
- out_ready  input  1  consumer takes result
- result  output  WIDTH  registered result
- zero  output  1  result == 0 (branch)
- overflow  output  1  signed overflow on add/sub
- illegal  output  1  undecodable alu_op/funct

Behaviour:
- Reset: all outputs 0 (out_valid, result, zero, overflow, illegal). State is IDLE. in_ready=1 after reset.
- Decode for alu_op=10, by funct:
  - 100000 add, 100001 addu, 100010 sub, 100011 subu
  - 100100 and, 100101 or, 100110 xor, 100111 nor
  - 101010 slt (signed), 101011 sltu
  - 000000 sll b<<shamt, 000010 srl, 000011 sra (arithmetic)
  - 011000 mul (only with ALU_MUL_EN)
  - Any other funct: illegal.
- For alu_op 00/11 use add; for 01 use sub.
- Acceptance: in_ready = (state==IDLE) && (!out_valid || out_ready). Accept on in_valid && in_ready.
- Single-cycle ops: result, zero, overflow and illegal are registered on the accept edge. out_valid=1 the next cycle; latency 1.
- Overflow is set only for add/sub/addi/branch-sub on signed overflow. It is 0 for addu/subu and for all other ops.
- Illegal op: result=0, zero=1, illegal=1. It completes like a normal op.
- slt/sltu give 1 or 0, zero-extended to WIDTH.
- Arithmetic wraps modulo 2^WIDTH.
- Output hold: while out_valid && !out_ready, all outputs stay stable and in_ready=0.
- Simultaneous pop and push: out_ready and a new accept in the same cycle replace the result with no bubble; out_valid stays 1.
- State machine:
  - IDLE: waits for accept.
  - MUL: entered on accepting mul; in_ready=0; runs WIDTH iterations.
  - Returns to IDLE with out_valid=1 when the count reaches WIDTH.
- Reset mid-operation aborts MUL. The result is discarded and out_valid is 0.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: funct 011000 performs unsigned shift-add multiply, one partial product per cycle. result = low WIDTH bits of a*b, overflow=0. Latency WIDTH+1 cycles from accept to out_valid.
- Not defined: the MUL state and counter are absent. 011000 decodes as illegal with latency 1.

Decomposition:
- Package alu_pkg holds:
  - ALU_OP_* (2-bit aluOp codes) and FUNCT_* constants.
  - A 4-bit alu_ctrl_t encoding: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, XOR 0011, NOR 1100, SLTU 1000, SLL 1001, SRL 1010, SRA 1011, MUL 1101, ILLEGAL 1111.
  - The first five codes keep the legacy encoding.
- Sub-module alu_ctrl_dec: purely combinational alu_op/funct -> alu_ctrl_t plus a signed-overflow-check flag. It is reusable by the single-cycle core.

Test Plan:
- Reset, then alu_op=10, funct=100000, a=0x7FFFFFFF, b=1, out_ready=1 -> next cycle out_valid=1, result=0x80000000, overflow=1, zero=0.
- alu_op=01, a=b=0x1234 -> result=0, zero=1, overflow=0. Then funct=101011 with a=1, b=0xFFFFFFFF -> result=1. Then funct=101010 with the same operands -> result=0.
- funct=000011, shamt=4, b=0xF0000000 -> result=0xFF000000. funct=000010 with the same inputs -> result=0x0F000000.
- Backpressure: out_ready=0 with back-to-back in_valid -> in_ready=0, outputs stable for 5 cycles. Raise out_ready -> next op accepted the same cycle, no loss or duplication; a scoreboard checks 100 random ops.
- funct=111111 -> illegal=1, result=0, zero=1. With ALU_MUL_EN undefined, funct=011000 also gives illegal=1 at latency 1.
- With ALU_MUL_EN: mul a=3, b=0xFFFFFFFF -> result=0xFFFFFFFD after 33 cycles, in_ready=0 throughout. A second run asserts reset at cycle 10 -> out_valid stays 0, state IDLE, in_ready=1.
